// File: rtl/mypipe_pkg.sv
// mypipe_pkg: shared widths and data type for the mypipe result collector.
package mypipe_pkg;
  localparam int N = 10;
  localparam int LAT = 3;
  localparam int DEPTH = 4;
  localparam int FW = $clog2(LAT + 1);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  typedef logic [N-1:0] pipe_data_t;
endpackage

// File: rtl/mypipe_result_collector_if.sv
// mypipe_result_collector_if: issue, pipe result, drain and status signals of the collector.
interface mypipe_result_collector_if;
  import mypipe_pkg::*;
  logic          issue_valid;
  logic          issue_ready;
  pipe_data_t    pipe_f;
  logic          out_valid;
  logic          out_ready;
  pipe_data_t    out_data;
  logic [FW-1:0] in_flight;
  logic [LW-1:0] level;
  logic          overflow;
  modport master (
    output issue_valid, pipe_f, out_ready,
    input  issue_ready, out_valid, out_data, in_flight, level, overflow
  );
  modport slave (
    input  issue_valid, pipe_f, out_ready,
    output issue_ready, out_valid, out_data, in_flight, level, overflow
  );
endinterface

// File: rtl/mypipe_res_fifo.sv
// mypipe_res_fifo: first-word-fall-through result FIFO with a registered head that holds after the last pop.
module mypipe_res_fifo
  import mypipe_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  pipe_data_t    din,
  output pipe_data_t    head,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  pipe_data_t    mem_q [DEPTH];
  pipe_data_t    head_d, head_q;
  logic [AW-1:0] wr_q, rd_q, rd_d;
  logic [LW-1:0] level_d, level_q, kept;
  logic          do_push, do_pop;
  assign full = level_q == LW'(DEPTH);
  assign empty = level_q == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign kept = level_q - LW'(do_pop);
  assign rd_d = rd_q + AW'(do_pop);
  assign level_d = kept + LW'(do_push);
  // Surviving entries win over the incoming word; an empty FIFO keeps the last popped value.
  assign head_d = kept != '0 ? mem_q[rd_d] : do_push ? din : head_q;
  assign head = head_q;
  assign level = level_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      head_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_d;
      level_q <= level_d;
      head_q <= head_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/mypipe_result_collector.sv
// mypipe_result_collector: tracks valid mypipe slots, captures pipe_f at fixed latency and drains it under credit control.
module mypipe_result_collector
  import mypipe_pkg::*;
(
  input logic clk,
  input logic rst_n,
  mypipe_result_collector_if.slave bus
);
  logic [LAT-1:0] vld_q, vld_d;
  logic [FW-1:0]  in_flight_q, in_flight_d;
  logic [LW-1:0]  level;
  logic           overflow_q, overflow_d;
  logic           accept, capture, pop, full, empty;
  assign capture = vld_q[LAT-1];
  assign accept = bus.issue_valid & bus.issue_ready;
  assign pop = bus.out_valid & bus.out_ready;
  // Credits come from registered counts only, so a pop frees a slot one cycle later.
  assign bus.issue_ready = int'(in_flight_q) + int'(level) < DEPTH;
  assign vld_d = {vld_q[LAT-2:0], accept};
  assign in_flight_d = in_flight_q + FW'(accept) - FW'(vld_q[LAT-1]);
  assign overflow_d = overflow_q | (capture & full & ~pop);
  assign bus.out_valid = ~empty;
  assign bus.level = level;
  assign bus.in_flight = in_flight_q;
  assign bus.overflow = overflow_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      in_flight_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      in_flight_q <= in_flight_d;
      overflow_q <= overflow_d;
    end
  end
  mypipe_res_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .pop   (pop),
    .din   (bus.pipe_f),
    .head  (bus.out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );
endmodule

// File: tb/tb_mypipe_result_collector.sv
// tb_mypipe_result_collector: directed checks of capture latency, credits, FIFO order and overflow.
module tb_mypipe_result_collector;
  import mypipe_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  pipe_data_t f_in = '0;
  pipe_data_t p0, p1, p2;
  mypipe_result_collector_if bus ();
  mypipe_result_collector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #10 clk = ~clk;
  // Stand-in for mypipe: the F value presented with the operands emerges LAT edges later.
  always @(posedge clk) begin
    p0 <= f_in;
    p1 <= p0;
    p2 <= p1;
  end
  assign bus.pipe_f = p2;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    int set4 [4] = '{75, 66, 112, 62};
    int set8 [8] = '{75, 66, 112, 62, 0, 66, 49, 116};
    int issued, got, max_lev;
    bus.issue_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    // 1: reset with results in flight
    bus.issue_valid = 1'b1; f_in = 10'd75;
    tick();
    bus.issue_valid = 1'b0; f_in = '0;
    tick();
    chk("t1_inflight_before_reset", 32'(bus.in_flight), 1);
    #5 rst_n = 1'b0;
    #1;
    chk("t1_rst_issue_ready", 32'(bus.issue_ready), 1);
    chk("t1_rst_out_valid", 32'(bus.out_valid), 0);
    chk("t1_rst_out_data", 32'(bus.out_data), 0);
    chk("t1_rst_in_flight", 32'(bus.in_flight), 0);
    chk("t1_rst_level", 32'(bus.level), 0);
    chk("t1_rst_overflow", 32'(bus.overflow), 0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("t1_no_spurious_level", 32'(bus.level), 0);
    chk("t1_no_spurious_valid", 32'(bus.out_valid), 0);
    // 2: single issue latency
    bus.issue_valid = 1'b1; f_in = 10'd75;
    tick();
    bus.issue_valid = 1'b0; f_in = '0;
    tick();
    tick();
    chk("t2_not_early", 32'(bus.out_valid), 0);
    tick();
    chk("t2_out_valid", 32'(bus.out_valid), 1);
    chk("t2_out_data", 32'(bus.out_data), 75);
    chk("t2_level", 32'(bus.level), 1);
    chk("t2_in_flight", 32'(bus.in_flight), 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t2_empty_after_pop", 32'(bus.out_valid), 0);
    chk("t2_data_held", 32'(bus.out_data), 75);
    // 3: fill with out_ready low, 5th issue refused
    for (int i = 0; i < 4; i++) begin
      bus.issue_valid = 1'b1; f_in = 10'(set4[i]);
      tick();
    end
    chk("t3_ready_low_after_4", 32'(bus.issue_ready), 0);
    f_in = 10'd99;
    repeat (5) tick();
    bus.issue_valid = 1'b0; f_in = '0;
    chk("t3_level_full", 32'(bus.level), 4);
    chk("t3_in_flight_zero", 32'(bus.in_flight), 0);
    chk("t3_ready_still_low", 32'(bus.issue_ready), 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_drain%0d", i), 32'(bus.out_data), 32'(set4[i]));
      tick();
    end
    bus.out_ready = 1'b0;
    chk("t3_drained_valid", 32'(bus.out_valid), 0);
    chk("t3_drained_level", 32'(bus.level), 0);
    // 4: streaming with out_ready high
    bus.out_ready = 1'b1;
    issued = 0; got = 0; max_lev = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      bus.issue_valid = issued < 8;
      f_in = issued < 8 ? 10'(set8[issued]) : '0;
      if (bus.out_valid) begin
        chk($sformatf("t4_result%0d", got), 32'(bus.out_data), 32'(set8[got]));
        got++;
      end
      if (bus.issue_valid && bus.issue_ready) issued++;
      tick();
      if (int'(bus.level) > max_lev) max_lev = int'(bus.level);
    end
    bus.issue_valid = 1'b0; bus.out_ready = 1'b0;
    chk("t4_all_results", 32'(got), 8);
    chk("t4_level_le1", 32'(max_lev <= 1), 1);
    chk("t4_overflow", 32'(bus.overflow), 0);
    // 5: pop coincides with capture while credits are exhausted
    for (int i = 0; i < 4; i++) begin
      bus.issue_valid = 1'b1; f_in = 10'(set4[i]);
      tick();
    end
    bus.issue_valid = 1'b0; f_in = '0;
    tick();
    tick();
    chk("t5_level_pre", 32'(bus.level), 3);
    chk("t5_in_flight_pre", 32'(bus.in_flight), 1);
    bus.out_ready = 1'b1;
    chk("t5_ready_in_pop_cycle", 32'(bus.issue_ready), 0);
    tick();
    bus.out_ready = 1'b0;
    chk("t5_level_kept", 32'(bus.level), 3);
    chk("t5_ready_after_pop", 32'(bus.issue_ready), 1);
    bus.out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("t5_order%0d", i), 32'(bus.out_data), 32'(set4[i]));
      tick();
    end
    bus.out_ready = 1'b0;
    chk("t5_empty", 32'(bus.level), 0);
    // 6: capture forced while full
    for (int i = 0; i < 4; i++) begin
      bus.issue_valid = 1'b1; f_in = 10'(set4[i]);
      tick();
    end
    bus.issue_valid = 1'b0; f_in = '0;
    repeat (3) tick();
    chk("t6_full", 32'(bus.level), 4);
    force dut.capture = 1'b1;
    tick();
    release dut.capture;
    chk("t6_overflow_set", 32'(bus.overflow), 1);
    chk("t6_level_unchanged", 32'(bus.level), 4);
    chk("t6_head_unchanged", 32'(bus.out_data), 75);
    repeat (3) tick();
    chk("t6_overflow_sticky", 32'(bus.overflow), 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_contents%0d", i), 32'(bus.out_data), 32'(set4[i]));
      tick();
    end
    bus.out_ready = 1'b0;
    chk("t6_sticky_after_drain", 32'(bus.overflow), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_clears", 32'(bus.overflow), 0);
    tick();
    rst_n = 1'b1;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
